// File: rtl/uart_pkg.sv
// Shared types and constants for the UART V3 receive path.
// Used by uart_rx_ctrl and uart_rx_sampler.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    DONE   = 3'd5
  } rx_state_e;

  localparam int MIN_PRESCALE = 4;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Line synchronizer, per-bit edge counter and mid-bit sampler for the UART receiver.
// Build option UART_RX_MAJORITY_EN: 2-of-3 vote over samples at mid-1, mid, mid+1.
module uart_rx_sampler
  import uart_pkg::*;
#(
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rxIn,
  input  logic                  run,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic                  rxSync,
  output logic                  bitEnd,
  output logic                  sampledBit
);

  localparam logic [PRESCALE_W-1:0] ONE = PRESCALE_W'(1);

  logic                  sync_p0;
  logic                  sync_p1;
  logic [PRESCALE_W-1:0] edgeCnt;
  logic [PRESCALE_W-1:0] mid;
  logic [PRESCALE_W-1:0] lastEdge;

  assign mid      = prescale >> 1;
  assign lastEdge = prescale - ONE;
  assign rxSync   = sync_p1;
  assign bitEnd   = run && (edgeCnt == lastEdge);

  // synchronizer idles high so a reset never looks like a start bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= rxIn;
      sync_p1 <= sync_p0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      edgeCnt <= '0;
    end else if (!run || bitEnd) begin
      edgeCnt <= '0;
    end else begin
      edgeCnt <= edgeCnt + ONE;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic sampLo;
  logic sampMid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sampLo     <= 1'b0;
      sampMid    <= 1'b0;
      sampledBit <= 1'b0;
    end else if (run) begin
      if (edgeCnt == mid - ONE) sampLo <= rxSync;
      if (edgeCnt == mid) sampMid <= rxSync;
      if (edgeCnt == mid + ONE) sampledBit <= maj3(sampLo, sampMid, rxSync);
    end
  end
`else
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sampledBit <= 1'b0;
    end else if (run && (edgeCnt == mid)) begin
      sampledBit <= rxSync;
    end
  end
`endif

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART V3 receive sequencer: walks start/data/parity/stop and strobes the deserializer and parity checker.
// Build option UART_RX_MAJORITY_EN (in uart_rx_sampler) selects majority-vote bit sampling.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATAWIDTH  = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rxIn,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  parEn,
  input  logic                  parErr,
  output logic                  sampledBit,
  output logic                  deSerEn,
  output logic                  deSerDn,
  output logic                  parityCheckEn,
  output logic                  done,
  output logic                  dataValid,
  output logic                  frameErr,
  output logic                  parityErr,
  output logic                  busy
);

  localparam int              BCW      = (DATAWIDTH > 1) ? $clog2(DATAWIDTH) : 1;
  localparam logic [BCW-1:0]  LAST_BIT = BCW'(DATAWIDTH - 1);
  localparam logic [BCW-1:0]  BC_ONE   = BCW'(1);

  rx_state_e      state_q, state_d;
  logic [BCW-1:0] bitCnt_q, bitCnt_d;
  logic           armed_q, armed_d;
  logic           frameErr_d, parityErr_d;
  logic           rxSync;
  logic           bitEnd;

  uart_rx_sampler #(
    .PRESCALE_W(PRESCALE_W)
  ) u_sampler (
    .clk       (clk),
    .rst       (rst),
    .rxIn      (rxIn),
    .run       (busy),
    .prescale  (prescale),
    .rxSync    (rxSync),
    .bitEnd    (bitEnd),
    .sampledBit(sampledBit)
  );

  assign busy      = (state_q != IDLE);
  assign dataValid = done && !(frameErr || parityErr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      bitCnt_q  <= '0;
      armed_q   <= 1'b0;
      frameErr  <= 1'b0;
      parityErr <= 1'b0;
    end else begin
      state_q   <= state_d;
      bitCnt_q  <= bitCnt_d;
      armed_q   <= armed_d;
      frameErr  <= frameErr_d;
      parityErr <= parityErr_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bitCnt_d      = bitCnt_q;
    armed_d       = armed_q;
    frameErr_d    = frameErr;
    parityErr_d   = parityErr;
    deSerEn       = 1'b0;
    deSerDn       = 1'b0;
    parityCheckEn = 1'b0;
    done          = 1'b0;

    case (state_q)
      // arming needs a high line first, so a held-low break cannot retrigger
      IDLE: begin
        if (rxSync) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d     = START;
          armed_d     = 1'b0;
          frameErr_d  = 1'b0;
          parityErr_d = 1'b0;
        end
      end
      START: begin
        if (bitEnd) begin
          if (sampledBit) begin
            state_d = IDLE;
          end else begin
            state_d  = DATA;
            bitCnt_d = '0;
          end
        end
      end
      DATA: begin
        if (bitEnd) begin
          deSerEn  = 1'b1;
          bitCnt_d = bitCnt_q + BC_ONE;
          if (bitCnt_q == LAST_BIT) begin
            deSerDn = 1'b1;
            state_d = parEn ? PARITY : STOP;
          end
        end
      end
      PARITY: begin
        if (bitEnd) begin
          parityCheckEn = 1'b1;
          state_d       = STOP;
        end
      end
      // a high stop bit pre-arms IDLE so a back-to-back start bit is not lost
      STOP: begin
        if (rxSync) armed_d = 1'b1;
        if (bitEnd) begin
          frameErr_d  = ~sampledBit;
          parityErr_d = parEn & parErr;
          state_d     = DONE;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
        if (rxSync) armed_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed and random frames against a frame-level model.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

  localparam int DW = 8;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rxIn = 1'b1;
  logic [PW-1:0] prescale = PW'(8);
  logic          parEn = 1'b0;
  logic          parErr = 1'b0;
  logic          sampledBit, deSerEn, deSerDn, parityCheckEn, done, dataValid;
  logic          frameErr, parityErr, busy;

  int checks = 0;
  int errors = 0;

  uart_rx_ctrl #(.DATAWIDTH(DW), .PRESCALE_W(PW)) dut (
    .clk(clk), .rst(rst), .rxIn(rxIn), .prescale(prescale), .parEn(parEn), .parErr(parErr),
    .sampledBit(sampledBit), .deSerEn(deSerEn), .deSerDn(deSerDn), .parityCheckEn(parityCheckEn),
    .done(done), .dataValid(dataValid), .frameErr(frameErr), .parityErr(parityErr), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // observation log, sampled on the falling edge
  int   nEn = 0, nDn = 0, nPce = 0, nDone = 0, nDv = 0, nViol = 0, doneCyc = 0;
  logic lastFe = 1'b0, lastPe = 1'b0, lastDv = 1'b0;
  logic injErr = 1'b0;
  logic bitLog [0:4095];

  always @(negedge clk) begin
    if (deSerEn) begin
      bitLog[nEn[11:0]] = sampledBit;
      nEn++;
    end
    if (deSerDn) nDn++;
    if (parityCheckEn) begin
      nPce++;
      parErr = injErr;
    end
    if (done) begin
      nDone++;
      doneCyc = cyc;
      lastFe  = frameErr;
      lastPe  = parityErr;
      lastDv  = dataValid;
      if (dataValid) nDv++;
      parErr = 1'b0;
    end
    if ((int'(deSerEn) + int'(parityCheckEn) + int'(done)) > 1 ||
        (deSerDn && !deSerEn) || (dataValid && !done))
      nViol++;
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int outs_vec();
    return int'({sampledBit, deSerEn, deSerDn, parityCheckEn, done, dataValid, frameErr, parityErr, busy});
  endfunction

  // drives one frame, one bit per P cycles; optional single-cycle inversion at (gBit, gOff)
  task automatic send_frame(input logic [DW-1:0] d, input logic pe, input logic stopv, input int P,
                            input int gBit, input int gOff, output int startCyc);
    logic bits[$];
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    if (pe) bits.push_back(^d);
    bits.push_back(stopv);
    startCyc = cyc;
    for (int b = 0; b < bits.size(); b++) begin
      for (int k = 0; k < P; k++) begin
        rxIn = (b == gBit && k == gOff) ? ~bits[b] : bits[b];
        @(negedge clk);
      end
    end
  endtask

  function automatic logic [DW-1:0] logged_word(input int base);
    logic [DW-1:0] w;
    for (int i = 0; i < DW; i++) w[i] = bitLog[12'(base + i)];
    return w;
  endfunction

  task automatic run_frame(input string tag, input logic [DW-1:0] d, input logic pe, input logic stopv,
                           input logic inj, input int P, input int gBit, input int gOff,
                           input logic [DW-1:0] expData);
    int   e0, d0, p0, n0, v0, st, nb;
    logic fe, pErr, dv;
    e0 = nEn; d0 = nDone; p0 = nPce; n0 = nDn; v0 = nDv;
    parEn = pe; injErr = inj; prescale = PW'(P);
    send_frame(d, pe, stopv, P, gBit, gOff, st);
    rxIn = 1'b1;
    repeat (P + 8) @(negedge clk);
    fe   = ~stopv;
    pErr = pe & inj;
    dv   = !(fe || pErr);
    nb   = 2 + DW + int'(pe);
    chk({tag, "/done_count"}, nDone - d0, 1);
    chk({tag, "/valid_count"}, nDv - v0, int'(dv));
    chk({tag, "/deser_en_count"}, nEn - e0, DW);
    chk({tag, "/deser_dn_count"}, nDn - n0, 1);
    chk({tag, "/parity_en_count"}, nPce - p0, int'(pe));
    chk({tag, "/frame_err"}, int'(lastFe), int'(fe));
    chk({tag, "/parity_err"}, int'(lastPe), int'(pErr));
    chk({tag, "/done_cycle"}, doneCyc - st, 3 + nb * P);
    chk({tag, "/data"}, int'(logged_word(e0)), int'(expData));
    chk({tag, "/busy_after"}, int'(busy), 0);
  endtask

  initial begin
    int st, st2, e0, d0, v0, diff, P;
    int Ps[5] = '{6, 8, 10, 12, 16};
    logic [DW-1:0] d, d2;
    logic pe, sv, inj;

    // reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs_vec(), 0);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("idle_outputs", outs_vec(), 0);

    // reference frame 0xA5 with parity
    run_frame("a5_par", 8'hA5, 1'b1, 1'b1, 1'b0, 8, -1, 0, 8'hA5);

    // broken stop bit, then a clean frame clears the error
    run_frame("a5_stop0", 8'hA5, 1'b1, 1'b0, 1'b0, 8, -1, 0, 8'hA5);
    chk("frame_err_hold", int'(frameErr), 1);
    run_frame("3c_clean", 8'h3C, 1'b1, 1'b1, 1'b0, 8, -1, 0, 8'h3C);
    chk("frame_err_cleared", int'(frameErr), 0);

    // parity error injected by the checker, then no parity bit at all
    run_frame("par_err", 8'h96, 1'b1, 1'b1, 1'b1, 8, -1, 0, 8'h96);
    chk("parity_err_hold", int'(parityErr), 1);
    run_frame("no_par", 8'h71, 1'b0, 1'b1, 1'b1, 8, -1, 0, 8'h71);

    // 2-cycle low glitch on an idle line at prescale 16
    prescale = PW'(16);
    e0 = nEn; d0 = nDone;
    rxIn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rxIn = 1'b1;
    @(negedge clk);
    chk("glitch/start_latency", int'(busy), 1);
    repeat (17) @(negedge clk);
    chk("glitch/back_idle", int'(busy), 0);
    chk("glitch/no_deser", nEn - e0, 0);
    chk("glitch/no_done", nDone - d0, 0);

    // single-cycle inversion at the sample point of data bit 2
`ifdef UART_RX_MAJORITY_EN
    run_frame("bit2_glitch", 8'h5A, 1'b0, 1'b1, 1'b0, 8, 3, 5, 8'h5A);
`else
    run_frame("bit2_glitch", 8'h5A, 1'b0, 1'b1, 1'b0, 8, 3, 5, 8'h5E);
`endif

    // random frames
    for (int n = 0; n < 12; n++) begin
      d   = DW'($urandom);
      pe  = 1'($urandom);
      sv  = ($urandom_range(0, 3) != 0);
      inj = 1'($urandom);
      P   = Ps[$urandom_range(0, 4)];
      run_frame("rand", d, pe, sv, inj, P, -1, 0, d);
    end

    // back-to-back frames with no idle gap
    d = DW'($urandom); d2 = DW'($urandom);
    parEn = 1'b0; injErr = 1'b0; prescale = PW'(8);
    e0 = nEn; d0 = nDone; v0 = nDv;
    send_frame(d, 1'b0, 1'b1, 8, -1, 0, st);
    send_frame(d2, 1'b0, 1'b1, 8, -1, 0, st2);
    rxIn = 1'b1;
    repeat (20) @(negedge clk);
    diff = doneCyc - st2;
    chk("b2b/done_count", nDone - d0, 2);
    chk("b2b/valid_count", nDv - v0, 2);
    chk("b2b/data0", int'(logged_word(e0)), int'(d));
    chk("b2b/data1", int'(logged_word(e0 + DW)), int'(d2));
    chk("b2b/late_start", int'(diff >= 3 + 10 * 8 && diff <= 5 + 10 * 8), 1);

    // line held low through reset release: one all-zero frame, then silence
    rst = 1'b0; rxIn = 1'b0; parEn = 1'b0; prescale = PW'(4);
    repeat (2) @(negedge clk);
    d0 = nDone; v0 = nDv;
    rst = 1'b1;
    repeat (100) @(negedge clk);
    chk("break/one_done", nDone - d0, 1);
    chk("break/no_valid", nDv - v0, 0);
    chk("break/frame_err", int'(lastFe), 1);
    chk("break/no_retrigger", int'(busy), 0);
    rxIn = 1'b1;
    repeat (10) @(negedge clk);
    run_frame("after_break", 8'hC3, 1'b0, 1'b1, 1'b0, 8, -1, 0, 8'hC3);

    // reset asserted during data bit 4
    prescale = PW'(8); parEn = 1'b0;
    d0 = nDone;
    rxIn = 1'b0;
    repeat (8) @(negedge clk);
    for (int b = 0; b < 4; b++) begin
      rxIn = 1'(b & 1);
      repeat (8) @(negedge clk);
    end
    rxIn = 1'b1;
    repeat (3) @(negedge clk);
    chk("midrst/busy_before", int'(busy), 1);
    rst = 1'b0;
    #1;
    chk("midrst/outputs_async", outs_vec(), 0);
    @(negedge clk);
    chk("midrst/busy_next", int'(busy), 0);
    rst = 1'b1;
    repeat (40) @(negedge clk);
    chk("midrst/no_done", nDone - d0, 0);
    run_frame("after_rst", 8'h0F, 1'b1, 1'b1, 1'b0, 8, -1, 0, 8'h0F);

    chk("pulse_exclusivity", nViol, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Receive-side sequencer for the UART V3 datapath. Oversamples the serial line and walks each frame through start, data, optional parity and stop. Issues the enable and strobe pulses that drive the deserializer and parity checker, and folds the checker's error into the frame status. Sits between the pin synchronizer and the rx datapath blocks (deserializer, parity checker).

Parameters:
DATAWIDTH, 8, data bits per frame
PRESCALE_W, 6, width of prescale input and edge counter

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-low
rxIn  in  1  raw serial line, idle high; 2-flop synchronized internally
prescale  in  PRESCALE_W  oversample clocks per bit; legal: even, >=4; static while busy
parEn  in  1  parity bit present in frame
parErr  in  1  parity checker error result, valid from 1 cycle after parityCheckEn
sampledBit  out  1  last sampled bit value; feeds deserializer and checker serial input
deSerEn  out  1  1-cycle pulse: shift sampledBit into deserializer
deSerDn  out  1  1-cycle pulse at end of last data bit
parityCheckEn  out  1  1-cycle pulse at end of parity bit
done  out  1  1-cycle end-of-frame pulse; clears downstream state
dataValid  out  1  1-cycle pulse with done when frame had no errors
frameErr  out  1  stop bit sampled 0; valid with done
parityErr  out  1  registered parErr; valid with done
busy  out  1  high in any state except IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, synchronizer flops 1.
- rxSync = rxIn delayed 2 clk. mid = prescale>>1. Edge counter edgeCnt counts 0..prescale-1 in every non-IDLE state, then wraps. "Bit end" = edgeCnt==prescale-1.
- Sample: sampledBit loads rxSync when edgeCnt==mid. Held until the next load.
- States:
  - IDLE: armed only after rxSync seen 1 (a held-low line/break never retriggers). Armed and rxSync==0 -> START, edgeCnt=0.
  - START: at bit end, sampledBit==1 (glitch) -> IDLE, no pulses. Otherwise -> DATA with bitCnt=0.
  - DATA: at each bit end, deSerEn=1 and bitCnt++. At bitCnt==DATAWIDTH-1 also deSerDn=1, then -> PARITY if parEn, else STOP.
  - PARITY: at bit end, parityCheckEn=1 -> STOP.
  - STOP: at bit end -> DONE. Latch frameErr=~sampledBit. Latch parityErr=parEn&parErr (0 when parEn=0).
  - DONE: one cycle. done=1, dataValid=~(frameErr|parityErr), then -> IDLE. IDLE is armed immediately if rxSync==1.
- frameErr/parityErr hold until the next START entry, where they clear to 0.
- Latency: start edge on rxIn to START entry = 3 clk. The done pulse falls in the cycle after stop bit end.
- Back-to-back frames: a start bit right after stop is caught; start detection is late by at most 2 clk.
- Reset mid-frame: immediate return to IDLE (disarmed until rxSync==1). No done pulse.
- Pulses are never simultaneous except deSerEn+deSerDn, and done+dataValid.

Optional Feature:
Macro UART_RX_MAJORITY_EN.
- Defined: sample rxSync at edgeCnt mid-1, mid, mid+1. sampledBit = 2-of-3 majority, loaded at edgeCnt==mid+1. All bit-end timing unchanged.
- Undefined: single sample at mid. The extra sample registers are absent.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP, DONE), 3-bit encoding;
  - the constant MIN_PRESCALE=4.
- One natural sub-module: uart_rx_sampler. It contains the synchronizer, edge counter, mid/bit-end compare and sampling/majority logic, and outputs bitEnd and sampledBit. The FSM stays in uart_rx_ctrl.

Test Plan:
- prescale=8, parEn=1, parErr tied 0, frame data 0xA5 LSB-first, stop=1 -> 8 deSerEn pulses with sampledBit sequence 1,0,1,0,0,1,0,1; one parityCheckEn; done+dataValid once, frameErr=0.
- Same frame, stop bit driven 0 -> done=1, dataValid=0, frameErr=1; next frame (0x3C) after line high -> dataValid=1, frameErr cleared.
- parEn=1, bench asserts parErr 1 cycle after parityCheckEn -> parityErr=1, dataValid=0 at done. parEn=0 -> no parityCheckEn, STOP follows DATA directly.
- rxIn low pulse of 2 clk (prescale=16) -> START entered, returns to IDLE at bit end; no deSerEn, no done.
- rxIn held low 100 clk after reset -> exactly one START/glitch-free sequence, then no retrigger until rxIn high. Assert rst at bit 4 of a frame -> all outputs 0, busy=0 next cycle.
- With UART_RX_MAJORITY_EN, single-clk inverted glitch at edge mid of data bit 2 -> bit still sampled correctly. Without the macro -> bit 2 corrupted.
